// File: rtl/psk_multi_dispatcher.sv
// CH parallel NCO + I/Q correlators on a 1-bit PSK input; each INT_LEN window is scanned for the largest |I|+|Q|.
// Result strobes INT_LEN+CH+1 cycles after reset release, then every INT_LEN cycles; no backpressure (free-running).
module psk_multi_dispatcher #(
    parameter int CH      = 4,
    parameter int PHASE_W = 13,
    parameter int INT_LEN = 256,
    parameter int ACC_W   = 10,
    parameter int MAG_W   = ACC_W + 1,
    parameter int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      sig,
    input  logic [CH*PHASE_W-1:0]     freq_words,
    output logic [MAG_W-1:0]          value,
    output logic [CH_W-1:0]           best_ch,
    output logic signed [ACC_W-1:0]   best_i,
    output logic signed [ACC_W-1:0]   best_q,
    output logic                      stb
);
    localparam int CNT_W = $clog2(INT_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(INT_LEN - 1);
    localparam logic [PHASE_W-1:0] QUARTER  = {2'b01, {(PHASE_W-2){1'b0}}};
    localparam logic [ACC_W-1:0]   PLUS1    = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]    IDX_LAST = CH_W'(CH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    logic [PHASE_W-1:0]      phase_q  [CH];
    logic [PHASE_W-1:0]      phase_d  [CH];
    logic [PHASE_W-1:0]      q_lead   [CH];
    logic signed [ACC_W-1:0] term_i   [CH];
    logic signed [ACC_W-1:0] term_q   [CH];
    logic signed [ACC_W-1:0] acc_i_q  [CH];
    logic signed [ACC_W-1:0] acc_i_d  [CH];
    logic signed [ACC_W-1:0] acc_q_q  [CH];
    logic signed [ACC_W-1:0] acc_q_d  [CH];
    logic signed [ACC_W-1:0] snap_i_q [CH];
    logic signed [ACC_W-1:0] snap_i_d [CH];
    logic signed [ACC_W-1:0] snap_q_q [CH];
    logic signed [ACC_W-1:0] snap_q_d [CH];

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [CH_W-1:0]         idx_q, idx_d;
    logic [MAG_W-1:0]        run_mag_q, run_mag_d;
    logic [CH_W-1:0]         run_ch_q, run_ch_d;
    logic signed [ACC_W-1:0] run_i_q, run_i_d, run_q_q, run_q_d;
    logic [MAG_W-1:0]        value_q, value_d;
    logic [CH_W-1:0]         best_ch_q, best_ch_d;
    logic signed [ACC_W-1:0] best_i_q, best_i_d, best_q_q, best_q_d;

    logic signed [ACC_W-1:0] cur_i, cur_q;
    logic [ACC_W-1:0]        abs_i, abs_q;
    logic [MAG_W-1:0]        mag;
    logic                    take;

    // The last sample of a window goes into the snapshot while the accumulators restart at zero.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        for (int k = 0; k < CH; k++) begin
            phase_d[k]  = phase_q[k] + freq_words[k*PHASE_W +: PHASE_W];
            q_lead[k]   = phase_q[k] + QUARTER;
            term_i[k]   = (sig == phase_q[k][PHASE_W-1]) ? PLUS1 : '1;
            term_q[k]   = (sig == q_lead[k][PHASE_W-1])  ? PLUS1 : '1;
            snap_i_d[k] = snap_i_q[k];
            snap_q_d[k] = snap_q_q[k];
            acc_i_d[k]  = acc_i_q[k] + term_i[k];
            acc_q_d[k]  = acc_q_q[k] + term_q[k];
            if (cnt_q == CNT_LAST) begin
                snap_i_d[k] = acc_i_d[k];
                snap_q_d[k] = acc_q_d[k];
                acc_i_d[k]  = '0;
                acc_q_d[k]  = '0;
            end
        end
    end

    always_comb begin
        cur_i     = snap_i_q[idx_q];
        cur_q     = snap_q_q[idx_q];
        abs_i     = cur_i[ACC_W-1] ? ACC_W'(-cur_i) : cur_i;
        abs_q     = cur_q[ACC_W-1] ? ACC_W'(-cur_q) : cur_q;
        mag       = MAG_W'(abs_i) + MAG_W'(abs_q);
        take      = (idx_q == '0) || (mag > run_mag_q);
        state_d   = state_q;
        idx_d     = idx_q;
        run_mag_d = run_mag_q;
        run_ch_d  = run_ch_q;
        run_i_d   = run_i_q;
        run_q_d   = run_q_q;
        value_d   = value_q;
        best_ch_d = best_ch_q;
        best_i_d  = best_i_q;
        best_q_d  = best_q_q;
        case (state_q)
            IDLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (take) begin
                    run_mag_d = mag;
                    run_ch_d  = idx_q;
                    run_i_d   = cur_i;
                    run_q_d   = cur_q;
                end
                idx_d = idx_q + CH_W'(1);
                // Final comparison feeds the output registers directly so they are valid with stb.
                if (idx_q == IDX_LAST) begin
                    state_d   = REPORT;
                    idx_d     = '0;
                    value_d   = run_mag_d;
                    best_ch_d = run_ch_d;
                    best_i_d  = run_i_d;
                    best_q_d  = run_q_d;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            for (int k = 0; k < CH; k++) begin
                phase_q[k]  <= '0;
                acc_i_q[k]  <= '0;
                acc_q_q[k]  <= '0;
                snap_i_q[k] <= '0;
                snap_q_q[k] <= '0;
            end
            cnt_q     <= '0;
            state_q   <= IDLE;
            idx_q     <= '0;
            run_mag_q <= '0;
            run_ch_q  <= '0;
            run_i_q   <= '0;
            run_q_q   <= '0;
            value_q   <= '0;
            best_ch_q <= '0;
            best_i_q  <= '0;
            best_q_q  <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                phase_q[k]  <= phase_d[k];
                acc_i_q[k]  <= acc_i_d[k];
                acc_q_q[k]  <= acc_q_d[k];
                snap_i_q[k] <= snap_i_d[k];
                snap_q_q[k] <= snap_q_d[k];
            end
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_mag_q <= run_mag_d;
            run_ch_q  <= run_ch_d;
            run_i_q   <= run_i_d;
            run_q_q   <= run_q_d;
            value_q   <= value_d;
            best_ch_q <= best_ch_d;
            best_i_q  <= best_i_d;
            best_q_q  <= best_q_d;
        end
    end

    assign value   = value_q;
    assign best_ch = best_ch_q;
    assign best_i  = best_i_q;
    assign best_q  = best_q_q;
    assign stb     = (state_q == REPORT);
endmodule
